// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scan driver with frame-synchronous data commit.
// Define SEG7_DP_EN to stage and display per-digit decimal points.
module seg7_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 262144
) (
  input  logic                CLK100MHZ,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] data,
  input  logic                load,
  input  logic [2:0]          duty,
  input  logic                blank_lz,
  input  logic [DIGITS-1:0]   dp,
  output logic [6:0]          seg,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an,
  output logic                frame,
  output logic                pending
);
  localparam int PW    = $clog2(DIV);
  localparam int IW    = $clog2(DIGITS);
  localparam int SLICE = DIV / 8;

  logic [PW-1:0]       pcnt_reg;
  logic [IW-1:0]       idx_reg;
  logic [4*DIGITS-1:0] staging_reg;
  logic [4*DIGITS-1:0] shadow_reg;
  logic                pending_reg;
  logic                wrap_reg;
  logic                boundary;
  logic                commit;

  logic [6:0]          seg_reg;
  logic                dp_n_reg;
  logic [DIGITS-1:0]   an_reg;
  logic                frame_reg;
  logic                pending_out_reg;

  assign boundary = (pcnt_reg == PW'(DIV - 1)) && (idx_reg == IW'(DIGITS - 1));
  // A load landing on the boundary takes priority and defers the commit a frame.
  assign commit   = boundary && pending_reg && !load;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg <= '0;
      idx_reg  <= '0;
    end else if (pcnt_reg == PW'(DIV - 1)) begin
      pcnt_reg <= '0;
      idx_reg  <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      pcnt_reg <= pcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      staging_reg <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      wrap_reg    <= 1'b0;
    end else begin
      wrap_reg <= boundary;
      if (load) begin
        staging_reg <= data;
        pending_reg <= 1'b1;
      end else if (commit) begin
        shadow_reg  <= staging_reg;
        pending_reg <= 1'b0;
      end
    end
  end

  logic dp_bit;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0] dp_stage_reg;
  logic [DIGITS-1:0] dp_shadow_reg;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      dp_stage_reg  <= '0;
      dp_shadow_reg <= '0;
    end else if (load) begin
      dp_stage_reg <= dp;
    end else if (commit) begin
      dp_shadow_reg <= dp_stage_reg;
    end
  end
  assign dp_bit = dp_shadow_reg[idx_reg];
`else
  logic unused_dp;
  assign unused_dp = ^dp;
  assign dp_bit    = 1'b0;
`endif

  // nib[i] is the shadow nibble of digit i; lz[i] flags nibbles i..top all zero.
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] lz;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi] = shadow_reg[4*gi +: 4];
      assign lz[gi]  = (shadow_reg[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [PW:0]       on_limit;
  logic              anode_on;
  logic              blank;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] an_next;
  logic              dp_n_next;

  assign on_limit  = (PW + 1)'((duty + 4'd1) * SLICE);
  assign anode_on  = ({1'b0, pcnt_reg} < on_limit);
  assign blank     = blank_lz && (idx_reg != '0) && lz[idx_reg];
  assign seg_next  = blank ? 7'b1111111 : hex7(nib[idx_reg]);
  assign an_next   = anode_on ? ~(DIGITS'(1) << idx_reg) : '1;
  assign dp_n_next = !(anode_on && !blank && dp_bit);

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg         <= 7'b1111111;
      dp_n_reg        <= 1'b1;
      an_reg          <= '1;
      frame_reg       <= 1'b0;
      pending_out_reg <= 1'b0;
    end else begin
      seg_reg         <= seg_next;
      dp_n_reg        <= dp_n_next;
      an_reg          <= an_next;
      frame_reg       <= wrap_reg;
      pending_out_reg <= pending_reg;
    end
  end

  assign seg     = seg_reg;
  assign dp_n    = dp_n_reg;
  assign an      = an_reg;
  assign frame   = frame_reg;
  assign pending = pending_out_reg;
endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, DIV=16) with a cycle-level reference model.
module tb_seg7_scan;
  localparam int D  = 4;
  localparam int DV = 16;
  localparam int FR = D * DV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   data = '0;
  logic          load = 1'b0;
  logic [2:0]    duty = 3'd7;
  logic          blank_lz = 1'b0;
  logic [3:0]    dp = '0;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame;
  logic          pending;

  always #5 clk = ~clk;

  seg7_scan #(.DIGITS(D), .DIV(DV)) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .data(data), .load(load), .duty(duty),
    .blank_lz(blank_lz), .dp(dp), .seg(seg), .dp_n(dp_n), .an(an),
    .frame(frame), .pending(pending)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int          m_n;
  logic [15:0] m_stage, m_shadow;
  logic [3:0]  m_dps, m_dpsh;
  bit          m_pend, m_wrap;

  // observation captures
  logic [6:0] cap_seg [D];
  int         on_cnt [D];
  int         dp_on [D];
  int         dp_stray;
  int         frame_cnt;
  bit         last_frame, last_pending;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_init();
    m_n = 0; m_stage = '0; m_shadow = '0; m_dps = '0; m_dpsh = '0;
    m_pend = 0; m_wrap = 0;
  endtask

  task automatic clear_caps();
    for (int i = 0; i < D; i++) begin
      cap_seg[i] = 7'h55; on_cnt[i] = 0; dp_on[i] = 0;
    end
    dp_stray = 0; frame_cnt = 0;
  endtask

  // One clock: predict outputs from the model, advance it, compare, then return at negedge.
  task automatic step();
    int pc, ix;
    bit on, blk, e_dpn;
    logic [6:0] e_seg, a_seg;
    logic [3:0] e_an, nibv, msk;
    logic [13:0] e_vec, a_vec;
    @(posedge clk);
    pc   = m_n % DV;
    ix   = (m_n / DV) % D;
    on   = pc < (int'(duty) + 1) * (DV / 8);
    nibv = m_shadow[4*ix +: 4];
    blk  = blank_lz && (ix > 0) && ((m_shadow >> (4*ix)) == 16'h0);
    e_seg = blk ? 7'h7F : hex_ref[nibv];
    e_an  = on ? ~(4'b1 << ix) : 4'hF;
`ifdef SEG7_DP_EN
    e_dpn = !(on && !blk && m_dpsh[ix]);
`else
    e_dpn = 1'b1;
`endif
    if (!on) e_seg = 7'h0;
    e_vec = {e_seg, e_an, e_dpn, m_wrap, m_pend};
    if (load) begin
      m_stage = data; m_dps = dp; m_pend = 1;
    end else if (pc == DV-1 && ix == D-1 && m_pend) begin
      m_shadow = m_stage; m_dpsh = m_dps; m_pend = 0;
    end
    m_wrap = (pc == DV-1 && ix == D-1);
    m_n++;
    #1;
    a_seg = (an == 4'hF) ? 7'h0 : seg;
    a_vec = {a_seg, an, dp_n, frame, pending};
    n_cmp++;
    if (a_vec !== e_vec) begin
      n_bad++;
      $display("FAIL model cyc=%0d: got seg=%h an=%b dp_n=%b frame=%b pending=%b expected seg=%h an=%b dp_n=%b frame=%b pending=%b",
               m_n, a_seg, an, dp_n, frame, pending, e_seg, e_an, e_dpn, m_wrap, m_pend);
    end
    for (int i = 0; i < D; i++) begin
      msk = 4'b1 << i;
      if (an == ~msk) begin
        cap_seg[i] = seg; on_cnt[i]++;
        if (dp_n == 1'b0) dp_on[i]++;
      end
    end
    if (an == 4'hF && dp_n == 1'b0) dp_stray++;
    if (frame) frame_cnt++;
    last_frame = frame; last_pending = pending;
    @(negedge clk);
  endtask

  task automatic steps(int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_frame(string tag);
    bit got = 0;
    for (int k = 0; k < 2*FR && !got; k++) begin
      step(); got = last_frame;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic align(int rem);
    for (int k = 0; k < FR && (m_n % FR) != rem; k++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0; load = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp_n", 32'(dp_n), 32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  task automatic chk_caps(string tag, logic [3:0][6:0] e);
    for (int i = 0; i < D; i++)
      chk($sformatf("%s_dig%0d", tag, i), 32'(cap_seg[i]), 32'(e[i]));
  endtask

  typedef struct packed {
    logic [15:0]     d;
    logic            blk;
    logic [3:0][6:0] e;
  } vec_t;
  vec_t vt [5];

  initial begin
    vt[0] = '{d: 16'h12AF, blk: 1'b0, e: {7'h79, 7'h24, 7'h08, 7'h0E}};
    vt[1] = '{d: 16'h0030, blk: 1'b1, e: {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vt[2] = '{d: 16'h0000, blk: 1'b1, e: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vt[3] = '{d: 16'h9C05, blk: 1'b1, e: {7'h10, 7'h46, 7'h40, 7'h12}};
    vt[4] = '{d: 16'h0B00, blk: 1'b1, e: {7'h7F, 7'h03, 7'h40, 7'h40}};

    model_init();
    clear_caps();
    do_reset();
    clear_caps();

    // free-running scan from reset
    step();
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'h40);
    steps(199);
    chk("frame_count", 32'(frame_cnt), 32'd3);

    // mid-frame loads, display checked one frame after commit
    for (int v = 0; v < 5; v++) begin
      blank_lz = vt[v].blk;
      align(20);
      data = vt[v].d; load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk($sformatf("vec%0d_pending_set", v), 32'(pending), 32'd1);
      wait_frame($sformatf("vec%0d_frame", v));
      chk($sformatf("vec%0d_pending_clr", v), 32'(last_pending), 32'd0);
      clear_caps();
      steps(63);
      chk_caps($sformatf("vec%0d", v), vt[v].e);
    end

    // load exactly on the boundary cycle: commit deferred one frame
    blank_lz = 1'b0;
    steps(2);
    align(FR - 1);
    data = 16'h4567; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame("bnd_frame1");
    chk("bnd_pending_hold", 32'(last_pending), 32'd1);
    clear_caps();
    steps(63);
    chk_caps("bnd_old", {7'h40, 7'h03, 7'h40, 7'h40});
    wait_frame("bnd_frame2");
    chk("bnd_pending_clr", 32'(last_pending), 32'd0);
    clear_caps();
    steps(63);
    chk_caps("bnd_new", {7'h19, 7'h12, 7'h02, 7'h78});

    // brightness extremes
    duty = 3'd0;
    wait_frame("duty0_frame");
    clear_caps();
    steps(64);
    for (int i = 0; i < D; i++) chk($sformatf("duty0_on%0d", i), 32'(on_cnt[i]), 32'd2);
    duty = 3'd7;
    wait_frame("duty7_frame");
    clear_caps();
    steps(64);
    for (int i = 0; i < D; i++) chk($sformatf("duty7_on%0d", i), 32'(on_cnt[i]), 32'd16);

    // decimal points
    duty = 3'd3;
    align(20);
    data = 16'h1234; dp = 4'b0100; load = 1'b1;
    step();
    load = 1'b0; dp = 4'b0000;
    wait_frame("dp_frame");
    clear_caps();
    steps(64);
`ifdef SEG7_DP_EN
    chk("dp_digit2", 32'(dp_on[2]), 32'd8);
    chk("dp_others", 32'(dp_on[0] + dp_on[1] + dp_on[3]), 32'd0);
`else
    chk("dp_disabled", 32'(dp_on[0] + dp_on[1] + dp_on[2] + dp_on[3]), 32'd0);
`endif
    chk("dp_stray", 32'(dp_stray), 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 700; k++) begin
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: data = 16'($urandom);
        1: data = 16'($urandom) & 16'h00FF;
        2: data = 16'($urandom) & 16'h000F;
        default: data = 16'h0000;
      endcase
      dp = 4'($urandom);
      if ($urandom_range(0, 31) == 0) duty = 3'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      step();
    end
    load = 1'b0;

    // reset mid-frame with data staged: staging discarded, scan restarts
    align(30);
    data = 16'hBEEF; dp = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    steps(3);
    do_reset();
    duty = 3'd7; blank_lz = 1'b0;
    steps(2 * FR + 2);
    chk("post_rst_pending", 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Parametrised multiplexed seven-segment display driver for the board top level. It replaces the hard-wired 8-digit scan loop clocked by a derived 380 Hz clock. The block runs on CLK100MHZ with an internal prescaler and adds tear-free frame-synchronous data loading, brightness control, leading-zero blanking and optional decimal points. It sits between the debug-data select logic and the board's `an`/`seg` pins.

## Interface
- DIGITS, 8, number of digits scanned (2..16)
- DIV, 262144, CLK100MHZ cycles per digit slot; multiple of 8, ≥ 16
- CLK100MHZ  in  1  board clock; sole clock
- rst_n  in  1  reset, asynchronous, active-low
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]
- load  in  1  single-cycle strobe; captures `data` into staging
- duty  in  3  brightness; anode on for (duty+1)/8 of each slot
- blank_lz  in  1  1 = suppress leading zero digits
- dp  in  DIGITS  decimal point request per digit (only with SEG7_DP_EN)
- seg  out  7  segments g..a, active-low
- dp_n  out  1  decimal point segment, active-low
- an  out  DIGITS  digit anodes, active-low, at most one low
- frame  out  1  one-cycle pulse when the scan returns to digit 0
- pending  out  1  staged data not yet committed to display

## Operation
- Prescaler `pcnt` counts 0..DIV-1 and wraps. Digit index `idx` increments when pcnt = DIV-1, and wraps DIGITS-1 → 0.
- Frame boundary: the cycle with pcnt = DIV-1 and idx = DIGITS-1.
- Data path: `load` writes `data` (and `dp`) into staging and sets pending = 1. At a frame boundary with pending = 1, staging moves into the shadow register and pending clears. The display reads only from the shadow register, so no frame mixes old and new data.
- Load at a boundary cycle: staging takes the new data, the shadow register is unchanged, and pending = 1. The commit happens at the next boundary.
- Back-to-back loads: the last one wins.
- Decode: 0–F using the standard hex patterns (0 = 1000000, 1 = 1111001, … F = 0001110).
- Leading-zero blanking: with blank_lz = 1, digit i (i > 0) is blanked (seg = 1111111, dp_n = 1) when shadow nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. An anode still drives during a blanked slot.
- Brightness: an[idx] is low only while pcnt < (duty+1)·(DIV/8). Otherwise all anodes are high.
- `duty` and `blank_lz` are sampled live; no commit step is applied to them.

## Timing
- Reset values: pcnt = 0, idx = 0, staging = 0, shadow = 0, pending = 0, seg = 1111111, dp_n = 1, an = all ones, frame = 0.
- All outputs are registered. Each output reflects the pcnt/idx/shadow state of the previous cycle, so latency is 1 cycle.
- First anode low: the cycle after rst_n deasserts. It shows digit 0 of the zero shadow, i.e. seg = 1000000, or blanked if that is ever permitted.
- Slot length is exactly DIV cycles. Frame length is DIGITS·DIV cycles.
- `frame` is high for the one cycle following each frame boundary. This is the same cycle in which an[0] first goes low with the new shadow.
- pending falls in that same cycle.
- Reset mid-frame: all state returns to reset values immediately, and staged data is discarded.

## Configuration
- SEG7_DP_EN defined: `dp` is staged and committed alongside `data`, and dp_n = ~dp[idx] (forced to 1 when the digit is blanked or its anode is off).
- SEG7_DP_EN undefined: `dp` is ignored, no dp staging registers exist, and dp_n is constantly 1.

## Test plan
- DIGITS = 4, DIV = 16. Release reset with no load: an cycles 1110 → 1101 → 1011 → 0111, 16 cycles each, seg = 1000000; frame pulses every 64 cycles.
- Load data = 16'h12AF mid-frame: pending = 1 until the boundary. The next frame shows F, A, 2, 1 on digits 0..3 (0001110, 0001000, 0100100, 1111001). No digit shows new data before frame rises.
- Load at the exact boundary cycle: the display keeps the old data for one more full frame, pending stays 1, then the commit happens.
- duty = 0: each anode is low for 2 of 16 cycles. duty = 7: each anode is low for all 16.
- blank_lz = 1 with data = 16'h0030: digits 3 and 2 are blanked (seg = 1111111), digit 1 shows 3, digit 0 shows 0. Data = 0: only digit 0 is lit.
- SEG7_DP_EN with dp = 4'b0100 loaded: dp_n = 0 only during the digit-2 anode-on window. Without the macro, dp_n stays 1 throughout.
